// File: rtl/axi4lite_native_responder_pkg.sv
// Shared types and constants for the AXI4-lite to native memory responder.
// Holds the FSM state encoding, AXI response codes and the last-served kind.
package axi4lite_native_responder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MEM_WR = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_RESP_B = 3'd3,
        ST_RESP_R = 3'd4
    } state_t;

    typedef enum logic {
        KIND_READ  = 1'b0,
        KIND_WRITE = 1'b1
    } kind_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/axi4lite_native_responder.sv
// AXI4-lite slave that replays each read/write as a single native mem_valid/mem_ready
// request; one native access in flight, one-deep capture buffer per AXI channel.
module axi4lite_native_responder
    import axi4lite_native_responder_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    output logic [1:0]  s_axi_bresp,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic        TMO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    state_t      state_r,     state_s;
    kind_t       last_served_r, last_served_s;
    logic        aw_full_r,   aw_full_s;
    logic        w_full_r,    w_full_s;
    logic        ar_full_r,   ar_full_s;
    logic [31:0] awaddr_r,    awaddr_s;
    logic [31:0] wdata_r,     wdata_s;
    logic [3:0]  wstrb_r,     wstrb_s;
    logic [31:0] araddr_r,    araddr_s;
    logic        arinstr_r,   arinstr_s;
    logic [31:0] tmo_cnt_r,   tmo_cnt_s;
    logic        mem_valid_r, mem_valid_s;
    logic        mem_instr_r, mem_instr_s;
    logic [31:0] mem_addr_r,  mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic [3:0]  mem_wstrb_r, mem_wstrb_s;
    logic        bvalid_r,    bvalid_s;
    logic [1:0]  bresp_r,     bresp_s;
    logic        rvalid_r,    rvalid_s;
    logic [1:0]  rresp_r,     rresp_s;
    logic [31:0] rdata_r,     rdata_s;
    logic        wr_pend_s, rd_pend_s, serve_wr_s, serve_rd_s, tmo_hit_s;
    logic        unused_prot_s;

    assign unused_prot_s = ^{s_axi_awprot, s_axi_arprot[1:0]};

    assign s_axi_awready = !aw_full_r;
    assign s_axi_wready  = !w_full_r;
    assign s_axi_arready = !ar_full_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rresp   = rresp_r;
    assign s_axi_rdata   = rdata_r;
    assign mem_valid     = mem_valid_r;
    assign mem_instr     = mem_instr_r;
    assign mem_addr      = mem_addr_r;
    assign mem_wdata     = mem_wdata_r;
    assign mem_wstrb     = mem_wstrb_r;

    // Next-state logic: channel capture, round-robin dispatch, native wait and response hold.
    always_comb begin
        state_s       = state_r;
        last_served_s = last_served_r;
        aw_full_s     = aw_full_r;
        w_full_s      = w_full_r;
        ar_full_s     = ar_full_r;
        awaddr_s      = awaddr_r;
        wdata_s       = wdata_r;
        wstrb_s       = wstrb_r;
        araddr_s      = araddr_r;
        arinstr_s     = arinstr_r;
        tmo_cnt_s     = tmo_cnt_r;
        mem_valid_s   = mem_valid_r;
        mem_instr_s   = mem_instr_r;
        mem_addr_s    = mem_addr_r;
        mem_wdata_s   = mem_wdata_r;
        mem_wstrb_s   = mem_wstrb_r;
        bvalid_s      = bvalid_r;
        bresp_s       = bresp_r;
        rvalid_s      = rvalid_r;
        rresp_s       = rresp_r;
        rdata_s       = rdata_r;

        wr_pend_s  = aw_full_r && w_full_r;
        rd_pend_s  = ar_full_r;
        serve_wr_s = wr_pend_s && (!rd_pend_s || (last_served_r == KIND_READ));
        serve_rd_s = rd_pend_s && !serve_wr_s;
        tmo_hit_s  = TMO_EN && (tmo_cnt_r == TMO_LAST);

        // A buffer can only be dispatched when full, so capture never collides with a clear.
        if (s_axi_awvalid && !aw_full_r) begin
            aw_full_s = 1'b1;
            awaddr_s  = s_axi_awaddr;
        end else begin
            aw_full_s = aw_full_s;
        end
        if (s_axi_wvalid && !w_full_r) begin
            w_full_s = 1'b1;
            wdata_s  = s_axi_wdata;
            wstrb_s  = s_axi_wstrb;
        end else begin
            w_full_s = w_full_s;
        end
        if (s_axi_arvalid && !ar_full_r) begin
            ar_full_s = 1'b1;
            araddr_s  = s_axi_araddr;
            arinstr_s = s_axi_arprot[2];
        end else begin
            ar_full_s = ar_full_s;
        end

        case (state_r)
            ST_IDLE: begin
                if (serve_wr_s) begin
                    aw_full_s   = 1'b0;
                    w_full_s    = 1'b0;
                    tmo_cnt_s   = 32'd0;
                    mem_addr_s  = word_addr(awaddr_r);
                    mem_wdata_s = wdata_r;
                    mem_wstrb_s = wstrb_r;
                    mem_instr_s = 1'b0;
                    // An all-zero strobe would look like a read natively, so answer it locally.
                    if (wstrb_r == 4'b0000) begin
                        bvalid_s      = 1'b1;
                        bresp_s       = RESP_OKAY;
                        last_served_s = KIND_WRITE;
                        state_s       = ST_RESP_B;
                    end else begin
                        mem_valid_s = 1'b1;
                        state_s     = ST_MEM_WR;
                    end
                end else if (serve_rd_s) begin
                    ar_full_s   = 1'b0;
                    tmo_cnt_s   = 32'd0;
                    mem_addr_s  = word_addr(araddr_r);
                    mem_wstrb_s = 4'b0000;
                    mem_instr_s = arinstr_r;
                    mem_valid_s = 1'b1;
                    state_s     = ST_MEM_RD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MEM_WR, ST_MEM_RD: begin
                if (mem_ready || tmo_hit_s) begin
                    mem_valid_s = 1'b0;
                    if (state_r == ST_MEM_WR) begin
                        bvalid_s      = 1'b1;
                        bresp_s       = mem_ready ? RESP_OKAY : RESP_SLVERR;
                        last_served_s = KIND_WRITE;
                        state_s       = ST_RESP_B;
                    end else begin
                        rvalid_s      = 1'b1;
                        rresp_s       = mem_ready ? RESP_OKAY : RESP_SLVERR;
                        rdata_s       = mem_ready ? mem_rdata : 32'd0;
                        last_served_s = KIND_READ;
                        state_s       = ST_RESP_R;
                    end
                end else begin
                    tmo_cnt_s = tmo_cnt_r + 32'd1;
                end
            end
            ST_RESP_B: begin
                if (s_axi_bready) begin
                    bvalid_s = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_RESP_B;
                end
            end
            ST_RESP_R: begin
                if (s_axi_rready) begin
                    rvalid_s = 1'b0;
                    state_s  = ST_IDLE;
                end else begin
                    state_s = ST_RESP_R;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            last_served_r <= KIND_READ;
            aw_full_r     <= 1'b0;
            w_full_r      <= 1'b0;
            ar_full_r     <= 1'b0;
            awaddr_r      <= 32'd0;
            wdata_r       <= 32'd0;
            wstrb_r       <= 4'd0;
            araddr_r      <= 32'd0;
            arinstr_r     <= 1'b0;
            tmo_cnt_r     <= 32'd0;
            mem_valid_r   <= 1'b0;
            mem_instr_r   <= 1'b0;
            mem_addr_r    <= 32'd0;
            mem_wdata_r   <= 32'd0;
            mem_wstrb_r   <= 4'd0;
            bvalid_r      <= 1'b0;
            bresp_r       <= 2'b00;
            rvalid_r      <= 1'b0;
            rresp_r       <= 2'b00;
            rdata_r       <= 32'd0;
        end else begin
            state_r       <= state_s;
            last_served_r <= last_served_s;
            aw_full_r     <= aw_full_s;
            w_full_r      <= w_full_s;
            ar_full_r     <= ar_full_s;
            awaddr_r      <= awaddr_s;
            wdata_r       <= wdata_s;
            wstrb_r       <= wstrb_s;
            araddr_r      <= araddr_s;
            arinstr_r     <= arinstr_s;
            tmo_cnt_r     <= tmo_cnt_s;
            mem_valid_r   <= mem_valid_s;
            mem_instr_r   <= mem_instr_s;
            mem_addr_r    <= mem_addr_s;
            mem_wdata_r   <= mem_wdata_s;
            mem_wstrb_r   <= mem_wstrb_s;
            bvalid_r      <= bvalid_s;
            bresp_r       <= bresp_s;
            rvalid_r      <= rvalid_s;
            rresp_r       <= rresp_s;
            rdata_r       <= rdata_s;
        end
    end

endmodule

// File: tb/tb_axi4lite_native_responder.sv
// Scoreboard bench for axi4lite_native_responder: expected native requests and AXI
// responses are queued at stimulus time and compared against monitored DUT traffic.
module tb_axi4lite_native_responder;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        instr;
    } req_t;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] data;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        mem_valid, mem_instr, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    logic        mem_auto, man_ready, model_ready;
    int          mem_wait, wait_cnt;
    logic [31:0] mem_data;

    int checks = 0;
    int failures = 0;
    int cyc = 0, rises = 0, ready_cyc = 0, b_rise_cyc = 0;
    logic mv_prev = 1'b0, bv_prev = 1'b0;

    req_t  exp_req_q[$], obs_req_q[$];
    resp_t exp_b_q[$], obs_b_q[$], exp_r_q[$], obs_r_q[$];
    bit    obs_kind_q[$];

    axi4lite_native_responder #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_ready = mem_auto ? model_ready : man_ready;
    assign mem_rdata = mem_data;

    // Native memory model: raise mem_ready after mem_wait extra cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_auto && mem_valid && !model_ready) begin
            if (wait_cnt >= mem_wait) begin
                model_ready <= 1'b1;
                wait_cnt    <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            model_ready <= 1'b0;
            if (!mem_valid) wait_cnt <= 0;
        end
    end

    // Monitor: record native requests, handshakes and response timing mid-cycle.
    always @(negedge clk) begin
        req_t r;
        mv_prev <= mem_valid;
        bv_prev <= s_axi_bvalid;
        if (mem_valid && !mv_prev) begin
            r.addr  = mem_addr;
            r.wdata = (mem_wstrb == 4'h0) ? 32'h0 : mem_wdata;
            r.wstrb = mem_wstrb;
            r.instr = mem_instr;
            obs_req_q.push_back(r);
            obs_kind_q.push_back(mem_wstrb != 4'h0);
            rises <= rises + 1;
        end
        if (mem_valid && mem_ready) ready_cyc <= cyc;
        if (s_axi_bvalid && !bv_prev) b_rise_cyc <= cyc;
        if (s_axi_bvalid && s_axi_bready) obs_b_q.push_back({s_axi_bresp, 32'h0});
        if (s_axi_rvalid && s_axi_rready) obs_r_q.push_back({s_axi_rresp, s_axi_rdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit rdy;
        int n = 0;
        s_axi_awaddr = a; s_axi_awvalid = 1'b1;
        do begin rdy = s_axi_awready; tick(); n++; end while (!rdy && n < 50);
        s_axi_awvalid = 1'b0;
        if (!rdy) begin checks++; failures++; $display("FAIL aw_accept: awready stayed 0, expected 1"); end
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit rdy;
        int n = 0;
        s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
        do begin rdy = s_axi_wready; tick(); n++; end while (!rdy && n < 50);
        s_axi_wvalid = 1'b0;
        if (!rdy) begin checks++; failures++; $display("FAIL w_accept: wready stayed 0, expected 1"); end
    endtask

    task automatic send_ar(input logic [31:0] a, input logic [2:0] p);
        bit rdy;
        int n = 0;
        s_axi_araddr = a; s_axi_arprot = p; s_axi_arvalid = 1'b1;
        do begin rdy = s_axi_arready; tick(); n++; end while (!rdy && n < 50);
        s_axi_arvalid = 1'b0;
        if (!rdy) begin checks++; failures++; $display("FAIL ar_accept: arready stayed 0, expected 1"); end
    endtask

    // sel: 0 B count>=n, 1 R count>=n, 2 mem_valid, 3 rvalid, 4 bvalid
    task automatic wait_for(input int sel, input int n, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (k < 200) begin
            case (sel)
                0: ok = (obs_b_q.size() >= n);
                1: ok = (obs_r_q.size() >= n);
                2: ok = (mem_valid === 1'b1);
                3: ok = (s_axi_rvalid === 1'b1);
                default: ok = (s_axi_bvalid === 1'b1);
            endcase
            if (ok) break;
            tick();
            k++;
        end
    endtask

    task automatic clear_obs();
        obs_req_q.delete(); obs_b_q.delete(); obs_r_q.delete(); obs_kind_q.delete();
        exp_req_q.delete(); exp_b_q.delete(); exp_r_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin failures++; $display("FAIL reset_readies: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
        checks++; if ({mem_valid, s_axi_bvalid, s_axi_rvalid} !== 3'b000) begin failures++; $display("FAIL reset_valids: got %b expected 000", {mem_valid, s_axi_bvalid, s_axi_rvalid}); end
        checks++; if ({s_axi_bresp, s_axi_rresp, s_axi_rdata, mem_wstrb} !== 40'h0) begin failures++; $display("FAIL reset_fields: got %h expected 0", {s_axi_bresp, s_axi_rresp, s_axi_rdata, mem_wstrb}); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write();
        bit ok;
        int r0;
        clear_obs();
        r0 = rises; mem_auto = 1'b1; mem_wait = 1; s_axi_bready = 1'b1;
        exp_req_q.push_back({32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 1'b0});
        exp_b_q.push_back({2'b00, 32'h0});
        fork
            send_w(32'hDEAD_BEEF, 4'hF);
            begin tick(); tick(); send_aw(32'h0000_1004); end
        join
        wait_for(0, 1, ok);
        checks++; if (!ok) begin failures++; $display("FAIL write_b_wait: no B, expected one"); end
        tick();
        checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL write_req_count: got %0d expected 1", rises - r0); end
        checks++; if (b_rise_cyc !== ready_cyc + 1) begin failures++; $display("FAIL write_b_latency: got cycle %0d expected %0d", b_rise_cyc, ready_cyc + 1); end
        while (exp_req_q.size() > 0) begin
            req_t e = exp_req_q.pop_front();
            req_t o = (obs_req_q.size() > 0) ? obs_req_q.pop_front() : '0;
            checks++; if (o !== e) begin failures++; $display("FAIL write_req: got %h expected %h", o, e); end
        end
        while (exp_b_q.size() > 0) begin
            resp_t e = exp_b_q.pop_front();
            resp_t o = (obs_b_q.size() > 0) ? obs_b_q.pop_front() : '1;
            checks++; if (o !== e) begin failures++; $display("FAIL write_bresp: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_read();
        bit ok;
        clear_obs();
        mem_auto = 1'b1; mem_wait = 0; mem_data = 32'h1234_5678; s_axi_rready = 1'b0;
        exp_req_q.push_back({32'h0000_0200, 32'h0, 4'h0, 1'b1});
        exp_r_q.push_back({2'b00, 32'h1234_5678});
        send_ar(32'h0000_0203, 3'b100);
        wait_for(3, 0, ok);
        checks++; if (!ok) begin failures++; $display("FAIL read_r_wait: no rvalid, expected 1"); end
        mem_data = 32'h0BAD_0BAD;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_axi_rvalid, s_axi_rresp, s_axi_rdata} !== {1'b1, 2'b00, 32'h1234_5678}) begin
                failures++; $display("FAIL read_hold: got %h expected %h", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, 2'b00, 32'h1234_5678});
            end
            tick();
        end
        s_axi_rready = 1'b1;
        wait_for(1, 1, ok);
        tick();
        checks++; if (s_axi_rvalid !== 1'b0) begin failures++; $display("FAIL read_rvalid_drop: got %b expected 0", s_axi_rvalid); end
        while (exp_req_q.size() > 0) begin
            req_t e = exp_req_q.pop_front();
            req_t o = (obs_req_q.size() > 0) ? obs_req_q.pop_front() : '1;
            checks++; if (o !== e) begin failures++; $display("FAIL read_req: got %h expected %h", o, e); end
        end
        while (exp_r_q.size() > 0) begin
            resp_t e = exp_r_q.pop_front();
            resp_t o = (obs_r_q.size() > 0) ? obs_r_q.pop_front() : '1;
            checks++; if (o !== e) begin failures++; $display("FAIL read_rresp: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_arbitration();
        bit ok, k0, k1;
        clear_obs();
        mem_auto = 1'b1; mem_wait = 0; s_axi_bready = 1'b1; s_axi_rready = 1'b1;
        fork
            send_aw(32'h0000_0010);
            send_w(32'h1111_1111, 4'hF);
            send_ar(32'h0000_0020, 3'b000);
        join
        wait_for(1, 1, ok);
        wait_for(0, 1, ok);
        k0 = (obs_kind_q.size() > 0) ? obs_kind_q.pop_front() : 1'b0;
        k1 = (obs_kind_q.size() > 0) ? obs_kind_q.pop_front() : 1'b1;
        checks++; if ({k0, k1} !== 2'b10) begin failures++; $display("FAIL arb_first: got order %b expected 10 (write,read)", {k0, k1}); end
        fork send_aw(32'h0000_0030); send_w(32'h2222_2222, 4'h3); join
        wait_for(0, 2, ok);
        tick();
        obs_kind_q.delete();
        fork
            send_aw(32'h0000_0040);
            send_w(32'h3333_3333, 4'hF);
            send_ar(32'h0000_0050, 3'b000);
        join
        wait_for(1, 2, ok);
        wait_for(0, 3, ok);
        checks++; if (!ok) begin failures++; $display("FAIL arb_wait: B count %0d expected 3", obs_b_q.size()); end
        k0 = (obs_kind_q.size() > 0) ? obs_kind_q.pop_front() : 1'b1;
        k1 = (obs_kind_q.size() > 0) ? obs_kind_q.pop_front() : 1'b0;
        checks++; if ({k0, k1} !== 2'b01) begin failures++; $display("FAIL arb_second: got order %b expected 01 (read,write)", {k0, k1}); end
        tick();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        clear_obs();
        mem_auto = 1'b0; man_ready = 1'b0; s_axi_rready = 1'b1; mem_data = 32'hCAFE_F00D;
        exp_r_q.push_back({2'b10, 32'h0});
        exp_r_q.push_back({2'b00, 32'hCAFE_F00D});
        send_ar(32'h0000_0300, 3'b000);
        wait_for(2, 0, ok);
        n = 0;
        while (mem_valid && n < 50) begin n++; tick(); end
        checks++; if (n !== 8) begin failures++; $display("FAIL tmo_valid_len: got %0d cycles expected 8", n); end
        wait_for(1, 1, ok);
        tick();
        send_ar(32'h0000_0304, 3'b000);
        wait_for(2, 0, ok);
        repeat (7) tick();
        man_ready = 1'b1;
        tick();
        man_ready = 1'b0;
        wait_for(1, 2, ok);
        tick();
        while (exp_r_q.size() > 0) begin
            resp_t e = exp_r_q.pop_front();
            resp_t o = (obs_r_q.size() > 0) ? obs_r_q.pop_front() : '1;
            checks++; if (o !== e) begin failures++; $display("FAIL tmo_rresp: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int r0;
        clear_obs();
        mem_auto = 1'b1; mem_wait = 0; s_axi_bready = 1'b0;
        r0 = rises;
        exp_b_q.push_back({2'b00, 32'h0});
        exp_b_q.push_back({2'b00, 32'h0});
        fork send_aw(32'h0000_0100); send_w(32'hAAAA_0001, 4'hF); join
        wait_for(4, 0, ok);
        fork send_aw(32'h0000_0104); send_w(32'hAAAA_0002, 4'hF); join
        repeat (4) tick();
        checks++; if ({s_axi_awready, s_axi_wready, s_axi_bvalid} !== 3'b001) begin failures++; $display("FAIL b2b_buffers: got %b expected 001", {s_axi_awready, s_axi_wready, s_axi_bvalid}); end
        checks++; if (rises - r0 !== 1) begin failures++; $display("FAIL b2b_blocked: got %0d requests expected 1", rises - r0); end
        s_axi_bready = 1'b1;
        wait_for(0, 2, ok);
        tick();
        checks++; if (rises - r0 !== 2) begin failures++; $display("FAIL b2b_second: got %0d requests expected 2", rises - r0); end
        while (exp_b_q.size() > 0) begin
            resp_t e = exp_b_q.pop_front();
            resp_t o = (obs_b_q.size() > 0) ? obs_b_q.pop_front() : '1;
            checks++; if (o !== e) begin failures++; $display("FAIL b2b_bresp: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_zero_strb();
        bit ok;
        int r0;
        clear_obs();
        s_axi_bready = 1'b1; r0 = rises;
        fork send_aw(32'h0000_0400); send_w(32'h5555_5555, 4'h0); join
        wait_for(0, 1, ok);
        tick();
        checks++; if (rises - r0 !== 0) begin failures++; $display("FAIL zstrb_noreq: got %0d requests expected 0", rises - r0); end
        checks++; if (obs_b_q.size() !== 1 || obs_b_q[0] !== {2'b00, 32'h0}) begin failures++; $display("FAIL zstrb_bresp: got %0d responses expected 1 OKAY", obs_b_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_obs();
        mem_auto = 1'b0; man_ready = 1'b0; s_axi_rready = 1'b1;
        send_ar(32'h0000_0500, 3'b000);
        wait_for(2, 0, ok);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if ({mem_valid, s_axi_rvalid} !== 2'b00) begin failures++; $display("FAIL rst_mid_valids: got %b expected 00", {mem_valid, s_axi_rvalid}); end
        checks++; if ({s_axi_awready, s_axi_wready, s_axi_arready} !== 3'b111) begin failures++; $display("FAIL rst_mid_readies: got %b expected 111", {s_axi_awready, s_axi_wready, s_axi_arready}); end
        repeat (20) tick();
        checks++; if (obs_r_q.size() !== 0 || rises > 0 && mem_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_noresp: got %0d R responses expected 0", obs_r_q.size()); end
    endtask

    initial begin
        reset = 1'b1;
        s_axi_awvalid = 1'b0; s_axi_awaddr = 32'h0; s_axi_awprot = 3'b000;
        s_axi_wvalid = 1'b0; s_axi_wdata = 32'h0; s_axi_wstrb = 4'h0;
        s_axi_bready = 1'b0; s_axi_arvalid = 1'b0; s_axi_araddr = 32'h0;
        s_axi_arprot = 3'b000; s_axi_rready = 1'b0;
        mem_auto = 1'b1; man_ready = 1'b0; model_ready = 1'b0;
        mem_wait = 0; wait_cnt = 0; mem_data = 32'h0;
        test_reset();
        test_write();
        test_read();
        test_arbitration();
        test_timeout();
        test_back_to_back();
        test_zero_strb();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi4lite_native_responder.md
Name: axi4lite_native_responder

Overview:
- AXI4-lite slave (responder) that accepts AXI4-lite read and write transactions and replays each as one native PicoRV32-style memory request (mem_valid/mem_ready handshake) toward a native-interface memory or peripheral.
- Reverse direction of the core-side native-to-AXI master adapter; lets existing native-bus RAMs/peripherals sit behind an AXI4-lite interconnect.
- One transaction outstanding on the native side; each AXI address/data channel has a one-deep capture buffer.

Parameters:
- TIMEOUT_CYCLES, 0, native-side wait limit in cycles before an SLVERR response; 0 disables the timeout.

Ports:
- clk  in  1  single clock
- reset  in  1  synchronous, active-high reset
- s_axi_awvalid  in  1  write address valid
- s_axi_awready  out  1  write address ready
- s_axi_awaddr  in  32  write address
- s_axi_awprot  in  3  ignored
- s_axi_wvalid  in  1  write data valid
- s_axi_wready  out  1  write data ready
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_bvalid  out  1  write response valid
- s_axi_bready  in  1  write response ready
- s_axi_bresp  out  2  00 = OKAY, 10 = SLVERR
- s_axi_arvalid  in  1  read address valid
- s_axi_arready  out  1  read address ready
- s_axi_araddr  in  32  read address
- s_axi_arprot  in  3  bit 2 drives mem_instr
- s_axi_rvalid  out  1  read data valid
- s_axi_rready  in  1  read data ready
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  00 = OKAY, 10 = SLVERR
- mem_valid  out  1  native request valid
- mem_instr  out  1  instruction fetch (arprot[2]); 0 on writes
- mem_ready  in  1  native request done
- mem_addr  out  32  {addr[31:2], 2'b00}
- mem_wdata  out  32  write data
- mem_wstrb  out  4  write strobes; 0 means read
- mem_rdata  in  32  read data, valid when mem_ready=1

Behaviour:
- Reset (synchronous, active-high): state IDLE; aw_full, w_full and ar_full cleared; mem_valid, bvalid and rvalid 0; bresp, rresp and rdata 0; mem_wstrb 0; last_served = READ.
- Capture buffers: awready = !aw_full, wready = !w_full, arready = !ar_full.
  - A handshake sets the corresponding full flag and latches the fields.
  - AW and W are independent and may arrive in either order or in the same cycle.
- Flags clear on the cycle the transaction is dispatched to the native side. A new AW/W/AR can therefore be captured while a native access is in flight.
- FSM states: IDLE, MEM_WR, MEM_RD, RESP_B, RESP_R.
- IDLE:
  - write pending = aw_full && w_full; read pending = ar_full.
  - Both pending: serve the kind opposite to last_served, so the first conflict after reset serves the write.
  - Only one pending: serve it.
  - Dispatch registers mem_valid=1 and mem_addr/mem_wdata/mem_wstrb/mem_instr, then moves to MEM_WR or MEM_RD.
  - Write dispatch drives mem_wstrb = captured wstrb. If that wstrb is 0, it is forced to 4'b0000 and the native request is skipped: go straight to RESP_B with OKAY, since wstrb=0 cannot be expressed as a write on the native side.
- MEM_WR / MEM_RD:
  - mem_valid and all mem_* outputs stay stable until mem_ready=1.
  - On mem_ready: mem_valid drops the next cycle; for a read, mem_rdata is latched into s_axi_rdata; the FSM moves to RESP_B (bvalid=1, bresp=OKAY) or RESP_R (rvalid=1, rresp=OKAY).
  - last_served is updated on this transition.
- Timeout (TIMEOUT_CYCLES > 0):
  - A counter clears on dispatch and increments each MEM_* cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES, mem_valid drops and the response carries SLVERR; rdata = 0 for reads.
  - If mem_ready and the timeout coincide, mem_ready wins (OKAY).
- RESP_B / RESP_R: bvalid/rvalid and the data/resp fields are held until bready/rready; then IDLE. A next dispatch is possible on the following cycle.
- Latency: from the last of AW/W (or AR) accepted with the FSM in IDLE, mem_valid rises 1 cycle later. B/R valid rises 1 cycle after the mem_ready cycle. Minimum round trip with zero-wait memory is 3 cycles.
- mem_ready while in IDLE or RESP_*: ignored.
- Reset mid-operation: all transactions are abandoned and there is no response. mem_valid drops on the cycle after reset is sampled.

Decomposition:
- Shared package:
  - FSM state enum (IDLE, MEM_WR, MEM_RD, RESP_B, RESP_R).
  - AXI response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Kind encoding for last_served.
- Single module; the capture buffers and timeout counter are too small to warrant sub-modules.

Test Plan:
- Write 0x0000_1004 / 0xDEADBEEF / wstrb 4'hF, W two cycles before AW, memory ready after 2 wait cycles -> exactly one mem_valid request with addr 0x0000_1004, wdata 0xDEADBEEF, wstrb F; bvalid with bresp 00 one cycle after mem_ready.
- Read 0x0000_0203 with arprot 3'b100, memory returns 0x12345678 -> mem_addr 0x0000_0200, mem_instr 1, mem_wstrb 0; rdata 0x12345678 with rresp 00; rvalid held 3 cycles under rready=0 with stable data.
- AW+W and AR presented in the same cycle after reset -> write served first, then read; the next simultaneous pair is served read first.
- TIMEOUT_CYCLES=8, mem_ready never asserted on a read -> mem_valid high for 8 cycles then low; rresp 10, rdata 0. Repeat with mem_ready in cycle 8 -> rresp 00.
- Back-to-back writes with bready=0 -> second AW/W accepted into buffers (awready/wready then low); no second mem_valid until first B accepted.
- reset asserted for 1 cycle during MEM_RD -> mem_valid 0, rvalid 0, all readies 1 the following cycle; no R response ever issued for the aborted read.
